// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - raster timing generator with undelayed fetch position and PIPE_DELAY-aligned sync/visible/strobes
// Optional raster-line interrupt is built when VGA_TIMING_PIPE_IRQ_EN is defined.
module vga_timing_pipe #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC_PULSE    = 64,
  parameter int H_BACK_PORCH    = 120,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT_PORCH   = 1,
  parameter int V_SYNC_PULSE    = 3,
  parameter int V_BACK_PORCH    = 16,
  parameter int H_SYNC_POSITIVE = 0,
  parameter int V_SYNC_POSITIVE = 0,
  parameter int PIPE_DELAY      = 2,
  parameter int FRAME_WIDTH     = 8,
  parameter int COL_WIDTH       = $clog2(H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH),
  parameter int ROW_WIDTH       = $clog2(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH)
) (
  input  logic                   dot_clk,
  input  logic                   reset,
  output logic [COL_WIDTH-1:0]   column,
  output logic [ROW_WIDTH-1:0]   line,
  output logic                   visible,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_WIDTH-1:0] frame_count,
  input  logic [ROW_WIDTH-1:0]   irq_line,
  input  logic                   irq_ack,
  output logic                   irq
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam int HS_START = H_VISIBLE + H_FRONT_PORCH;
  localparam int HS_END   = HS_START + H_SYNC_PULSE;
  localparam int VS_START = V_VISIBLE + V_FRONT_PORCH;
  localparam int VS_END   = VS_START + V_SYNC_PULSE;

  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(H_TOTAL - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(V_TOTAL - 1);

  logic        col_wrap;
  logic        row_wrap;
  logic [31:0] col_ext;
  logic [31:0] row_ext;

  assign col_wrap = (column == COL_LAST);
  assign row_wrap = (line == ROW_LAST);
  assign col_ext  = 32'(column);
  assign row_ext  = 32'(line);

  always_ff @(posedge dot_clk) begin
    if (reset) begin
      column      <= '0;
      line        <= '0;
      frame_count <= '0;
    end else begin
      column <= col_wrap ? '0 : column + COL_WIDTH'(1);
      if (col_wrap) begin
        line <= row_wrap ? '0 : line + ROW_WIDTH'(1);
        if (row_wrap) begin
          frame_count <= frame_count + FRAME_WIDTH'(1);
        end
      end
    end
  end

  // Stage-0 terms, all active-high: {vis, hs, vs, ls, fs}
  logic       vis_raw;
  logic       hs_raw;
  logic       vs_raw;
  logic       ls_raw;
  logic       fs_raw;
  logic [4:0] raw_terms;
  logic [4:0] out_terms;

  assign vis_raw   = (col_ext < 32'(H_VISIBLE)) && (row_ext < 32'(V_VISIBLE));
  assign hs_raw    = (col_ext >= 32'(HS_START)) && (col_ext < 32'(HS_END));
  assign vs_raw    = (row_ext >= 32'(VS_START)) && (row_ext < 32'(VS_END));
  assign ls_raw    = (column == '0);
  assign fs_raw    = ls_raw && (line == '0);
  assign raw_terms = {vis_raw, hs_raw, vs_raw, ls_raw, fs_raw};

  generate
    if (PIPE_DELAY == 0) begin : g_direct
      assign out_terms = raw_terms;
    end else begin : g_pipe
      // Zero in every stage means "inactive"; sync polarity is applied after the chain
      logic [4:0] stage [PIPE_DELAY];

      always_ff @(posedge dot_clk) begin
        if (reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= raw_terms;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign out_terms = stage[PIPE_DELAY-1];
    end
  endgenerate

  assign visible     = out_terms[4];
  assign hsync       = (H_SYNC_POSITIVE != 0) ? out_terms[3] : ~out_terms[3];
  assign vsync       = (V_SYNC_POSITIVE != 0) ? out_terms[2] : ~out_terms[2];
  assign line_start  = out_terms[1];
  assign frame_start = out_terms[0];

`ifdef VGA_TIMING_PIPE_IRQ_EN
  // Fires at the start of h-blank on irq_line; a set in the same cycle as an ack wins
  logic irq_hit;

  assign irq_hit = (col_ext == 32'(H_VISIBLE)) && (line == irq_line);

  always_ff @(posedge dot_clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (irq_hit) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = ^{irq_line, irq_ack};
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb/tb_vga_timing_pipe.sv - scoreboard bench for vga_timing_pipe (default, small-raster and zero-delay instances)
module tb_vga_timing_pipe;

`ifdef VGA_TIMING_PIPE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic dot_clk = 1'b0;
  logic reset   = 1'b1;
  logic s_ack   = 1'b0;

  always #5 dot_clk = ~dot_clk;

  // Default geometry, PIPE_DELAY=2
  logic [9:0] d_col;
  logic [8:0] d_line;
  logic       d_vis, d_hs, d_vs, d_ls, d_fs, d_irq_unused;
  logic [7:0] d_fc;

  vga_timing_pipe u_d (
    .dot_clk(dot_clk), .reset(reset), .column(d_col), .line(d_line),
    .visible(d_vis), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls),
    .frame_start(d_fs), .frame_count(d_fc), .irq_line(9'd10),
    .irq_ack(1'b0), .irq(d_irq_unused)
  );

  // Small raster: H_TOTAL=16, V_TOTAL=8, 128 cycles per frame, 2-bit frame counter
  logic [3:0] s_col;
  logic [2:0] s_line;
  logic       s_vis, s_hs, s_vs, s_ls, s_fs, s_irq;
  logic [1:0] s_fc;

  vga_timing_pipe #(
    .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(3), .H_BACK_PORCH(3),
    .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(1),
    .PIPE_DELAY(2), .FRAME_WIDTH(2)
  ) u_s (
    .dot_clk(dot_clk), .reset(reset), .column(s_col), .line(s_line),
    .visible(s_vis), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls),
    .frame_start(s_fs), .frame_count(s_fc), .irq_line(3'd1),
    .irq_ack(s_ack), .irq(s_irq)
  );

  // Zero-delay, positive hsync
  logic [9:0] z_col_unused;
  logic [8:0] z_line_unused;
  logic       z_vis, z_hs, z_vs_unused, z_ls_unused, z_fs_unused, z_irq_unused;
  logic [7:0] z_fc_unused;

  vga_timing_pipe #(.PIPE_DELAY(0), .H_SYNC_POSITIVE(1)) u_z (
    .dot_clk(dot_clk), .reset(reset), .column(z_col_unused), .line(z_line_unused),
    .visible(z_vis), .hsync(z_hs), .vsync(z_vs_unused), .line_start(z_ls_unused),
    .frame_start(z_fs_unused), .frame_count(z_fc_unused), .irq_line(9'd0),
    .irq_ack(1'b0), .irq(z_irq_unused)
  );

  localparam int D_COL = 0, D_LINE = 1, D_VIS = 2, D_HS = 3, D_VS = 4, D_LS = 5, D_FS = 6, D_FC = 7;
  localparam int S_COL = 8, S_LINE = 9, S_VIS = 10, S_HS = 11, S_VS = 12, S_LS = 13, S_FS = 14;
  localparam int S_FC = 15, S_IRQ = 16, Z_VIS = 17, Z_HS = 18;

  typedef struct {
    int          epoch;
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   epoch      = -1;
  int   cyc        = 0;
  logic prev_rst   = 1'b0;

  function automatic string sig_name(input int s);
    case (s)
      D_COL: return "d_column";   D_LINE: return "d_line";    D_VIS: return "d_visible";
      D_HS:  return "d_hsync";    D_VS:   return "d_vsync";   D_LS:  return "d_line_start";
      D_FS:  return "d_frame_start"; D_FC: return "d_frame_count";
      S_COL: return "s_column";   S_LINE: return "s_line";    S_VIS: return "s_visible";
      S_HS:  return "s_hsync";    S_VS:   return "s_vsync";   S_LS:  return "s_line_start";
      S_FS:  return "s_frame_start"; S_FC: return "s_frame_count"; S_IRQ: return "s_irq";
      Z_VIS: return "z_visible";  Z_HS:   return "z_hsync";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int s);
    case (s)
      D_COL: return 32'(d_col);   D_LINE: return 32'(d_line); D_VIS: return 32'(d_vis);
      D_HS:  return 32'(d_hs);    D_VS:   return 32'(d_vs);   D_LS:  return 32'(d_ls);
      D_FS:  return 32'(d_fs);    D_FC:   return 32'(d_fc);
      S_COL: return 32'(s_col);   S_LINE: return 32'(s_line); S_VIS: return 32'(s_vis);
      S_HS:  return 32'(s_hs);    S_VS:   return 32'(s_vs);   S_LS:  return 32'(s_ls);
      S_FS:  return 32'(s_fs);    S_FC:   return 32'(s_fc);   S_IRQ: return 32'(s_irq);
      Z_VIS: return 32'(z_vis);   Z_HS:   return 32'(z_hs);
      default: return 32'hffff_ffff;
    endcase
  endfunction

  task automatic expect_at(input int e, input int c, input int s, input logic [31:0] v);
    exp_t item;
    item.epoch = e; item.cyc = c; item.sig = s; item.val = v;
    q.push_back(item);
  endtask

  // Cycle t of an epoch = state after t non-reset edges following the last reset edge
  always @(posedge dot_clk) begin
    if (reset) begin
      if (!prev_rst) epoch = epoch + 1;
      cyc = 0;
    end else begin
      cyc = cyc + 1;
    end
    prev_rst = reset;
  end

  always @(negedge dot_clk) begin
    if (epoch >= 0) begin
      while (q.size() > 0 && (q[0].epoch < epoch || (q[0].epoch == epoch && q[0].cyc < cyc))) begin
        compared++; mismatched++;
        $display("FAIL %s missed: epoch %0d cycle %0d never sampled", sig_name(q[0].sig), q[0].epoch, q[0].cyc);
        void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].epoch == epoch && q[0].cyc == cyc) begin
        compared++;
        if (actual(q[0].sig) !== q[0].val) begin
          mismatched++;
          $display("FAIL %s @ epoch %0d cycle %0d: got %0d, expected %0d",
                   sig_name(q[0].sig), epoch, cyc, actual(q[0].sig), q[0].val);
        end
        void'(q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int e, input int c);
    int n = 0;
    while (!(epoch == e && cyc == c) && n < 5000) begin
      @(posedge dot_clk); #1;
      n++;
    end
    if (n >= 5000) begin
      compared++; mismatched++;
      $display("FAIL wait_cyc: reached epoch %0d cycle %0d, wanted epoch %0d cycle %0d", epoch, cyc, e, c);
    end
  endtask

  initial begin
    // Epoch 0, in cycle order
    expect_at(0, 0, D_COL, 0);   expect_at(0, 0, D_LINE, 0);  expect_at(0, 0, D_VIS, 0);
    expect_at(0, 0, D_HS, 1);    expect_at(0, 0, D_VS, 1);    expect_at(0, 0, D_LS, 0);
    expect_at(0, 0, D_FS, 0);    expect_at(0, 0, D_FC, 0);    expect_at(0, 0, S_VIS, 0);
    expect_at(0, 0, S_HS, 1);    expect_at(0, 0, S_VS, 1);    expect_at(0, 0, S_FC, 0);
    expect_at(0, 0, S_IRQ, 0);   expect_at(0, 0, Z_VIS, 1);   expect_at(0, 0, Z_HS, 0);
    expect_at(0, 1, D_VIS, 0);   expect_at(0, 1, D_LS, 0);
    expect_at(0, 2, D_VIS, 1);   expect_at(0, 2, D_LS, 1);    expect_at(0, 2, D_FS, 1);
    expect_at(0, 2, S_VIS, 1);   expect_at(0, 2, S_FS, 1);
    expect_at(0, 3, D_LS, 0);    expect_at(0, 3, D_FS, 0);
    expect_at(0, 9, S_VIS, 1);   expect_at(0, 10, S_VIS, 0);
    expect_at(0, 11, S_HS, 1);   expect_at(0, 12, S_HS, 0);   expect_at(0, 14, S_HS, 0);
    expect_at(0, 15, S_HS, 1);
    expect_at(0, 16, S_COL, 0);  expect_at(0, 16, S_LINE, 1);
    expect_at(0, 17, S_LS, 0);   expect_at(0, 18, S_LS, 1);   expect_at(0, 18, S_FS, 0);
    expect_at(0, 24, S_IRQ, 0);  expect_at(0, 25, S_IRQ, 32'(IRQ_ON));
    expect_at(0, 40, S_IRQ, 32'(IRQ_ON)); expect_at(0, 50, S_IRQ, 32'(IRQ_ON));
    expect_at(0, 51, S_IRQ, 0);
    expect_at(0, 81, S_VS, 1);   expect_at(0, 82, S_VS, 0);   expect_at(0, 113, S_VS, 0);
    expect_at(0, 114, S_VS, 1);
    expect_at(0, 127, S_FC, 0);  expect_at(0, 128, S_FC, 1);  expect_at(0, 128, S_COL, 0);
    expect_at(0, 128, S_LINE, 0); expect_at(0, 129, S_FS, 0); expect_at(0, 130, S_FS, 1);
    expect_at(0, 152, S_IRQ, 0); expect_at(0, 153, S_IRQ, 32'(IRQ_ON));
    expect_at(0, 511, S_FC, 3);  expect_at(0, 512, S_FC, 0);
    expect_at(0, 639, Z_VIS, 1); expect_at(0, 640, Z_VIS, 0);
    expect_at(0, 641, D_VIS, 1); expect_at(0, 642, D_VIS, 0);
    expect_at(0, 655, Z_HS, 0);  expect_at(0, 656, Z_HS, 1);
    expect_at(0, 657, D_HS, 1);  expect_at(0, 658, D_HS, 0);
    expect_at(0, 719, Z_HS, 1);  expect_at(0, 720, Z_HS, 0);
    expect_at(0, 721, D_HS, 0);  expect_at(0, 722, D_HS, 1);
    expect_at(0, 839, D_COL, 839); expect_at(0, 839, D_LINE, 0);
    expect_at(0, 840, D_COL, 0); expect_at(0, 840, D_LINE, 1);
    expect_at(0, 841, D_VIS, 0); expect_at(0, 841, D_LS, 0);
    expect_at(0, 842, D_VIS, 1); expect_at(0, 842, D_LS, 1);  expect_at(0, 842, D_FS, 0);
    expect_at(0, 860, D_COL, 20); expect_at(0, 860, S_VS, 0); expect_at(0, 860, S_FC, 2);
    expect_at(0, 860, S_LINE, 5); expect_at(0, 860, S_COL, 12);
    // Epoch 1: after a one-cycle reset mid-frame
    expect_at(1, 0, S_COL, 0);   expect_at(1, 0, S_LINE, 0);  expect_at(1, 0, S_VIS, 0);
    expect_at(1, 0, S_HS, 1);    expect_at(1, 0, S_VS, 1);    expect_at(1, 0, S_FC, 0);
    expect_at(1, 0, S_IRQ, 0);   expect_at(1, 0, D_COL, 0);   expect_at(1, 0, D_FC, 0);
    expect_at(1, 0, D_HS, 1);
    expect_at(1, 1, S_VIS, 0);   expect_at(1, 2, S_VIS, 1);   expect_at(1, 2, S_FS, 1);
    expect_at(1, 10, S_COL, 10);

    repeat (3) @(posedge dot_clk);
    #1 reset = 1'b0;
    wait_cyc(0, 50);
    s_ack = 1'b1;
    @(posedge dot_clk); #1 s_ack = 1'b0;
    wait_cyc(0, 152);
    s_ack = 1'b1;
    @(posedge dot_clk); #1 s_ack = 1'b0;
    wait_cyc(0, 860);
    reset = 1'b1;
    @(posedge dot_clk); #1 reset = 1'b0;
    wait_cyc(1, 12);
    @(negedge dot_clk);
    while (q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL %s unchecked: epoch %0d cycle %0d", sig_name(q[0].sig), q[0].epoch, q[0].cyc);
      void'(q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
